cv32e40p_fetch_fifo_par: RTL and testbench

Parity-protected instruction prefetch FIFO placed directly upstream of the instruction aligner. It buffers 32-bit fetch words returned by the instruction-memory interface and presents them to the aligner through a valid/ready handshake. Each stored word carries an even-parity bit, so storage upsets are detected when the word leaves the FIFO. Branch and hardware-loop redirections flush the FIFO in a single cycle.

---
 rtl/cv32e40p_pkg.sv | 15 +
 rtl/cv32e40p_fetch_fifo_par.sv | 104 ++++++++++
 tb/tb_cv32e40p_fetch_fifo_par.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared constants and helpers for the cv32e40p fetch path
//
// Purpose : default prefetch FIFO depth and the even-parity helper used when
//           storing and checking fetch words.
package cv32e40p_pkg;

    localparam int FETCH_FIFO_DEPTH = 4;

    // Even parity over a fetch word: the stored bit makes the 33-bit
    // {parity, data} vector have an even number of ones.
    function automatic logic par_even(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/cv32e40p_fetch_fifo_par.sv
// rtl/cv32e40p_fetch_fifo_par.sv - parity-protected instruction prefetch FIFO
//
// Purpose : buffers 32-bit fetch words ahead of the instruction aligner, tags
//           each entry with an even-parity bit and flags corrupted heads.
// Ports   : clk, rst_n          clock, asynchronous active-low reset
//           flush_i             redirect, empties the FIFO in one cycle
//           in_valid_i/in_ready_o/in_rdata_i     upstream fetch handshake
//           out_valid_o/out_ready_i/out_rdata_o  aligner handshake
//           cnt_o               occupancy
//           parity_err_o        head entry fails its parity check
//           err_cnt_o           saturating count of popped corrupted entries
module cv32e40p_fetch_fifo_par
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH    = FETCH_FIFO_DEPTH,
    parameter int ERRCNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [31:0]                in_rdata_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic                       parity_err_o,
    output logic [ERRCNT_W-1:0]        err_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [32:0]         fifo_q [DEPTH];
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                push, pop;
    logic [32:0]         head;

    // Flags come from registered state only, so no input-to-output paths.
    assign in_ready_o   = (cnt_q != DEPTH_C);
    assign out_valid_o  = (cnt_q != '0);
    assign head         = fifo_q[rptr_q];
    assign out_rdata_o  = head[31:0];
    assign parity_err_o = out_valid_o && (par_even(head[31:0]) != head[32]);
    assign cnt_o        = cnt_q;
    assign err_cnt_o    = err_cnt_q;

    // Flush overrides both handshakes; a pop never frees space for a
    // same-cycle push when full because in_ready_o is registered-state only.
    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    always_comb begin
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;

        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        if (pop && parity_err_o && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q    <= '0;
            wptr_q    <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= {par_even(in_rdata_i), in_rdata_i};
        end
    end

endmodule

// File: tb/tb_cv32e40p_fetch_fifo_par.sv
// tb/tb_cv32e40p_fetch_fifo_par.sv - directed self-checking bench for the prefetch FIFO
module tb_cv32e40p_fetch_fifo_par;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [2:0]  cnt_o;
    logic        parity_err_o;
    logic [7:0]  err_cnt_o;

    int total;
    int bad;

    cv32e40p_fetch_fifo_par #(.DEPTH(4), .ERRCNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_rdata_i   (in_rdata_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_rdata_o  (out_rdata_o),
        .cnt_o        (cnt_o),
        .parity_err_o (parity_err_o),
        .err_cnt_o    (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        in_valid_i = 1'b1;
        in_rdata_i = w;
        cyc();
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready_o); end
        total++;
        if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid_o); end
        total++;
        if (cnt_o !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
        total++;
        if (parity_err_o !== 1'b0) begin bad++; $display("FAIL reset_parity_err got=%0b exp=0", parity_err_o); end
        total++;
        if (err_cnt_o !== 8'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt_o); end
    endtask

    task automatic test_order();
        logic [31:0] words [3];
        words[0] = 32'h0000_0013;
        words[1] = 32'h0041_0093;
        words[2] = 32'hFFFF_FFFF;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_rdata_i = words[i];
            cyc();
        end
        in_valid_i = 1'b0;
        total++;
        if (cnt_o !== 3'd3) begin bad++; $display("FAIL order_cnt got=%0d exp=3", cnt_o); end
        total++;
        if (out_rdata_o !== 32'h0000_0013) begin bad++; $display("FAIL order_head got=%08h exp=00000013", out_rdata_o); end
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid_o !== 1'b1 || out_rdata_o !== words[i]) begin
                bad++; $display("FAIL order_pop%0d got=%08h v=%0b exp=%08h", i, out_rdata_o, out_valid_o, words[i]);
            end
            total++;
            if (parity_err_o !== 1'b0) begin bad++; $display("FAIL order_parity%0d got=%0b exp=0", i, parity_err_o); end
            cyc();
        end
        out_ready_i = 1'b0;
        total++;
        if (out_valid_o !== 1'b0 || cnt_o !== 3'd0) begin
            bad++; $display("FAIL order_empty got v=%0b cnt=%0d exp v=0 cnt=0", out_valid_o, cnt_o);
        end
    endtask

    task automatic test_full();
        logic [31:0] words [4];
        words[0] = 32'hA000_0001;
        words[1] = 32'hA000_0002;
        words[2] = 32'hA000_0003;
        words[3] = 32'hA000_0004;
        for (int i = 0; i < 4; i++) push_word(words[i]);
        total++;
        if (in_ready_o !== 1'b0 || cnt_o !== 3'd4) begin
            bad++; $display("FAIL full_flags got rdy=%0b cnt=%0d exp rdy=0 cnt=4", in_ready_o, cnt_o);
        end
        push_word(32'hDEAD_BEEF);
        total++;
        if (cnt_o !== 3'd4) begin bad++; $display("FAIL full_ignore_cnt got=%0d exp=4", cnt_o); end
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_rdata_o !== words[i]) begin
                bad++; $display("FAIL full_drain%0d got=%08h exp=%08h", i, out_rdata_o, words[i]);
            end
            cyc();
        end
        out_ready_i = 1'b0;
        total++;
        if (cnt_o !== 3'd0 || out_valid_o !== 1'b0) begin
            bad++; $display("FAIL full_empty got cnt=%0d v=%0b exp cnt=0 v=0", cnt_o, out_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base = 32'hB000_0000;
        push_word(base + 32'd0);
        push_word(base + 32'd1);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_rdata_i = base + 32'(i + 2);
            total++;
            if (out_rdata_o !== base + 32'(i) || cnt_o !== 3'd2) begin
                bad++; $display("FAIL b2b_%0d got=%08h cnt=%0d exp=%08h cnt=2", i, out_rdata_o, cnt_o, base + 32'(i));
            end
            cyc();
        end
        in_valid_i = 1'b0;
        for (int i = 10; i < 12; i++) begin
            total++;
            if (out_rdata_o !== base + 32'(i)) begin
                bad++; $display("FAIL b2b_drain%0d got=%08h exp=%08h", i, out_rdata_o, base + 32'(i));
            end
            cyc();
        end
        out_ready_i = 1'b0;
        total++;
        if (cnt_o !== 3'd0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", cnt_o); end
    endtask

    task automatic test_flush();
        push_word(32'hC000_0001);
        push_word(32'hC000_0002);
        push_word(32'hC000_0003);
        flush_i     = 1'b1;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        in_rdata_i  = 32'hBAD0_BAD0;
        cyc();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        total++;
        if (cnt_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            bad++; $display("FAIL flush_state got cnt=%0d v=%0b rdy=%0b exp cnt=0 v=0 rdy=1", cnt_o, out_valid_o, in_ready_o);
        end
        push_word(32'hC000_00AA);
        total++;
        if (cnt_o !== 3'd1 || out_rdata_o !== 32'hC000_00AA) begin
            bad++; $display("FAIL flush_next got=%08h cnt=%0d exp=c00000aa cnt=1", out_rdata_o, cnt_o);
        end
        out_ready_i = 1'b1;
        cyc();
        out_ready_i = 1'b0;
    endtask

    task automatic test_parity();
        for (int n = 0; n < 256; n++) begin
            flush_i = 1'b1;
            cyc();
            flush_i = 1'b0;
            push_word(32'h1234_5678);
            dut.fifo_q[0] = dut.fifo_q[0] ^ 33'd1;
            #1;
            total++;
            if (parity_err_o !== 1'b1 || out_rdata_o !== 32'h1234_5679) begin
                bad++; $display("FAIL parity_head%0d got err=%0b data=%08h exp err=1 data=12345679", n, parity_err_o, out_rdata_o);
            end
            out_ready_i = 1'b1;
            cyc();
            out_ready_i = 1'b0;
            if (n == 0) begin
                total++;
                if (err_cnt_o !== 8'd1) begin bad++; $display("FAIL parity_errcnt1 got=%0d exp=1", err_cnt_o); end
            end
        end
        total++;
        if (err_cnt_o !== 8'd255) begin bad++; $display("FAIL parity_saturate got=%0d exp=255", err_cnt_o); end
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        total++;
        if (err_cnt_o !== 8'd255) begin bad++; $display("FAIL parity_flush_keep got=%0d exp=255", err_cnt_o); end
    endtask

    task automatic test_async_reset();
        push_word(32'hE000_0001);
        push_word(32'hE000_0002);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid_o !== 1'b0 || cnt_o !== 3'd0 || err_cnt_o !== 8'd0 || in_ready_o !== 1'b1) begin
            bad++; $display("FAIL async_reset got v=%0b cnt=%0d err=%0d rdy=%0b exp v=0 cnt=0 err=0 rdy=1",
                            out_valid_o, cnt_o, err_cnt_o, in_ready_o);
        end
        cyc();
        rst_n = 1'b1;
        push_word(32'hE000_00F0);
        total++;
        if (cnt_o !== 3'd1 || out_rdata_o !== 32'hE000_00F0) begin
            bad++; $display("FAIL post_reset_push got=%08h cnt=%0d exp=e00000f0 cnt=1", out_rdata_o, cnt_o);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_rdata_i  = 32'h0;
        out_ready_i = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        test_reset();
        test_order();
        test_full();
        test_back_to_back();
        test_flush();
        test_parity();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
